// File: rtl/reg_entry_pkg.sv
// Shared types and constants for the front-panel register entry block.
// Digit bookkeeping is derived from the nibble width.
package reg_entry_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_e;

  localparam int NIBBLE_W   = 4;
  localparam int DEF_DATA_W = 32;
  localparam int MAX_DIGITS = DEF_DATA_W / NIBBLE_W;

  function automatic int max_digits(input int data_w);
    return data_w / NIBBLE_W;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, level debouncer and a
// single-cycle registered press pulse on each accepted 0->1 change.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             differ_s;

  assign differ_s = (sync2_q != stable_q);

  // Next-state for the run counter, stable level and press pulse
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    press_d  = 1'b0;
    if (differ_s) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = ~stable_q;
        press_d  = ~stable_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchronizer and debounce state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= raw;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/reg_entry.sv
// Front-panel hex entry: builds a value nibble by nibble from debounced
// buttons and writes it to the register file through a ready handshake.
module reg_entry
  import reg_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int DATA_W          = 32,
  parameter int ADDR_W          = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_shift,
  input  logic              btn_commit,
  input  logic              btn_clear,
  input  logic [3:0]        sw_nibble,
  input  logic [ADDR_W-1:0] sw_addr,
  input  logic              wr_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] entry_value,
  output logic [3:0]        digit_count
);

  localparam logic [3:0] DIGITS_MAX = 4'(max_digits(DATA_W));

  logic shift_ev_s, commit_ev_s, clear_ev_s;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_shift (
    .clk(clk), .reset(reset), .raw(btn_shift), .press(shift_ev_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_commit (
    .clk(clk), .reset(reset), .raw(btn_commit), .press(commit_ev_s)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_clear (
    .clk(clk), .reset(reset), .raw(btn_clear), .press(clear_ev_s)
  );

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] entry_q, entry_d;
  logic [3:0]        count_q, count_d;

  // FSM next-state; clear beats commit beats shift, all ignored while writing
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    entry_d = entry_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        we_d = 1'b0;
        if (clear_ev_s) begin
          entry_d = '0;
          count_d = 4'd0;
        end else if (commit_ev_s) begin
          // register 0 is hardwired, so committing to it does nothing
          if (sw_addr != '0) begin
            waddr_d = sw_addr;
            wdata_d = entry_q;
            we_d    = 1'b1;
            state_d = WRITE;
          end else begin
            state_d = IDLE;
          end
        end else if (shift_ev_s) begin
          entry_d = {entry_q[DATA_W-NIBBLE_W-1:0], sw_nibble};
          if (count_q != DIGITS_MAX) begin
            count_d = count_q + 4'd1;
          end else begin
            count_d = count_q;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (we_q && wr_ready) begin
          we_d    = 1'b0;
          entry_d = '0;
          count_d = 4'd0;
          state_d = IDLE;
        end else begin
          we_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  // Entry, counter, FSM and write-port registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      entry_q <= '0;
      count_q <= 4'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      entry_q <= entry_d;
      count_q <= count_d;
    end
  end

  assign we          = we_q;
  assign waddr       = waddr_q;
  assign wdata       = wdata_q;
  assign entry_value = entry_q;
  assign digit_count = count_q;

endmodule

// File: tb/tb_reg_entry.sv
// Self-checking bench for reg_entry: a button/entry model compared every
// cycle, plus directed scenarios with literal expectations.
module tb_reg_entry;

  localparam int D = 4;

  logic        clk;
  logic        reset;
  logic [2:0]  btn;          // [0]=shift [1]=commit [2]=clear
  logic [3:0]  sw_nibble;
  logic [4:0]  sw_addr;
  logic        wr_ready;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] entry_value;
  logic [3:0]  digit_count;

  int checks = 0;
  int failures = 0;
  int we_cycles = 0;
  int mark;
  logic chk_en = 1'b0;

  reg_entry #(.DEBOUNCE_CYCLES(D), .DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .reset(reset),
    .btn_shift(btn[0]), .btn_commit(btn[1]), .btn_clear(btn[2]),
    .sw_nibble(sw_nibble), .sw_addr(sw_addr), .wr_ready(wr_ready),
    .we(we), .waddr(waddr), .wdata(wdata),
    .entry_value(entry_value), .digit_count(digit_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: a button press is accepted once D consecutive raw samples disagree
  // with the accepted level; it acts on the entry 3 edges after the D-th sample.
  logic [D-1:0] m_hist [3];
  logic [2:0]   m_stable;
  logic [2:0]   m_pipe [3];
  logic         m_we;
  logic [4:0]   m_waddr;
  logic [31:0]  m_wdata, m_entry;
  logic [3:0]   m_cnt;

  always @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < 3; b++) begin
        m_hist[b] <= '0;
        m_pipe[b] <= 3'b000;
      end
      m_stable <= 3'b000;
      m_we <= 1'b0; m_waddr <= 5'd0; m_wdata <= 32'd0;
      m_entry <= 32'd0; m_cnt <= 4'd0;
    end else begin
      for (int b = 0; b < 3; b++) begin
        m_hist[b] <= {m_hist[b][D-2:0], btn[b]};
        if ({m_hist[b][D-2:0], btn[b]} == {D{~m_stable[b]}}) begin
          m_stable[b] <= btn[b];
          m_pipe[b]   <= {m_pipe[b][1:0], btn[b]};
        end else begin
          m_pipe[b]   <= {m_pipe[b][1:0], 1'b0};
        end
      end
      if (m_we) begin
        if (wr_ready) begin
          m_we <= 1'b0; m_entry <= 32'd0; m_cnt <= 4'd0;
        end
      end else if (m_pipe[2][2]) begin
        m_entry <= 32'd0; m_cnt <= 4'd0;
      end else if (m_pipe[1][2]) begin
        if (sw_addr != 5'd0) begin
          m_we <= 1'b1; m_waddr <= sw_addr; m_wdata <= m_entry;
        end
      end else if (m_pipe[0][2]) begin
        m_entry <= (m_entry << 4) | {28'd0, sw_nibble};
        m_cnt   <= (m_cnt < 4'd8) ? m_cnt + 4'd1 : m_cnt;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("we", {31'd0, we}, {31'd0, m_we});
      chk("waddr", {27'd0, waddr}, {27'd0, m_waddr});
      chk("wdata", wdata, m_wdata);
      chk("entry_value", entry_value, m_entry);
      chk("digit_count", {28'd0, digit_count}, {28'd0, m_cnt});
      if (we) we_cycles++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input int b, input int hold);
    btn[b] = 1'b1;
    cyc(hold);
    btn[b] = 1'b0;
    cyc(10);
  endtask

  task automatic wait_we();
    for (int i = 0; i < 20 && !we; i++) cyc(1);
    chk("we_rise", {31'd0, we}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; btn = 3'b111; sw_nibble = 4'h0; sw_addr = 5'd0; wr_ready = 1'b0;
    // 1: reset with buttons toggling, then quiet
    cyc(1);
    chk_en = 1'b1;
    btn = 3'b000;
    cyc(1);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      cyc(1);
      chk("post_reset", {we, waddr, digit_count} | entry_value | wdata, 32'd0);
    end

    // 2: held shift lands exactly at edge D+3
    sw_nibble = 4'hA;
    btn[0] = 1'b1;
    for (int k = 1; k <= D + 2; k++) begin
      cyc(1);
      chk("shift_early", entry_value, 32'd0);
    end
    cyc(1);
    chk("shift_edge7", entry_value, 32'h0000000A);
    cyc(12 - (D + 3));
    btn[0] = 1'b0;
    cyc(10);
    sw_nibble = 4'h5;
    press(0, 12);
    chk("entry_A5", entry_value, 32'h000000A5);
    chk("count_2", {28'd0, digit_count}, 32'd2);

    // 3: a 3-cycle glitch is discarded, a 4-cycle press is one shift
    sw_nibble = 4'h3;
    press(0, 3);
    chk("glitch3", entry_value, 32'h000000A5);
    press(0, 4);
    chk("pulse4", entry_value, 32'h00000A53);

    // 4: nine digits, oldest one drops out, counter saturates
    press(2, 6);
    chk("clear", entry_value, 32'd0);
    for (int n = 1; n <= 9; n++) begin
      sw_nibble = 4'(n);
      press(0, 6);
    end
    chk("entry_9dig", entry_value, 32'h23456789);
    chk("count_sat", {28'd0, digit_count}, 32'd8);

    // 5: write with ready held low for 3 cycles; shift during WRITE dropped
    press(2, 6);
    for (int n = 0; n < 8; n++) begin
      sw_nibble = 4'((32'hDEADBEEF >> (28 - 4 * n)) & 32'hF);
      press(0, 6);
    end
    chk("entry_deadbeef", entry_value, 32'hDEADBEEF);
    sw_addr = 5'd5;
    sw_nibble = 4'h9;
    mark = we_cycles;
    btn[1] = 1'b1;
    cyc(2);
    btn[0] = 1'b1;
    wait_we();
    chk("waddr_5", {27'd0, waddr}, 32'd5);
    chk("wdata_db", wdata, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("we_hold", {31'd0, we}, 32'd1);
      chk("wdata_hold", wdata, 32'hDEADBEEF);
    end
    wr_ready = 1'b1;
    cyc(1);
    chk("we_drop", {31'd0, we}, 32'd0);
    chk("entry_cleared", entry_value, 32'd0);
    cyc(1);
    chk("we_len", we_cycles - mark, 32'd4);
    btn = 3'b000;
    cyc(10);
    chk("shift_dropped", entry_value, 32'd0);

    // 6a: commit to register 0 is ignored
    sw_nibble = 4'h7;
    press(0, 6);
    sw_addr = 5'd0;
    mark = we_cycles;
    press(1, 8);
    chk("zero_no_we", we_cycles - mark, 32'd0);
    chk("zero_keep", entry_value, 32'h00000007);

    // 6b: clear and commit together -> clear wins
    sw_addr = 5'd3;
    btn[1] = 1'b1; btn[2] = 1'b1;
    cyc(8);
    btn = 3'b000;
    cyc(10);
    chk("clr_commit_entry", entry_value, 32'd0);
    chk("clr_commit_no_we", we_cycles - mark, 32'd0);

    // 6c: reset in the middle of WRITE
    sw_nibble = 4'h1;
    press(0, 6);
    wr_ready = 1'b0;
    btn[1] = 1'b1;
    wait_we();
    reset = 1'b1;
    cyc(1);
    chk("reset_we", {31'd0, we}, 32'd0);
    chk("reset_entry", entry_value, 32'd0);
    reset = 1'b0;
    btn = 3'b000;
    cyc(10);
    chk("after_reset_we", {31'd0, we}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
